// File: rtl/int_pkg.sv
// Shared definitions for the jacaranda-8 interrupt controller: FSM encoding,
// register window addresses and CTRL field positions.
package int_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ADDR_CTRL         = 2'd0,
      ADDR_VBASE        = 2'd1,
      ADDR_PEND         = 2'd2,
      ADDR_SWSET_STATUS = 2'd3
   } reg_addr_t;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MASK_LSB = 4;

   // Writable CTRL bits: the global enable plus one mask bit per source.
   function automatic logic [7:0] ctrl_wmask(input int n_src);
      logic [7:0] m;
      m = '0;
      m[CTRL_EN_BIT] = 1'b1;
      for (int i = 0; i < n_src; i++) m[CTRL_MASK_LSB + i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module int_prio_enc
   #(parameter int N_SRC = 4)
   (
   input  logic [N_SRC-1:0] req,
   output logic             valid,
   output logic [1:0]       idx
   );

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      valid = 1'b0;
      idx   = 2'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = 2'(i);
         end
      end
   end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge-latched pending bits, masked fixed-priority pick,
// one single-cycle request per service, then wait for the core's return strobe.
module int_controller
   import int_pkg::*;
   #(parameter int N_SRC     = 4,
     parameter int VEC_SHIFT = 4)
   (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq,
   input  logic             ret,
   input  logic             cfg_w_en,
   input  logic [1:0]       cfg_addr,
   input  logic [7:0]       cfg_w_data,
   output logic [7:0]       cfg_r_data,
   output logic             int_req,
   output logic [7:0]       int_en,
   output logic [7:0]       int_vec
   );

   localparam logic [7:0] CTRL_WMASK = ctrl_wmask(N_SRC);

   state_t           state, next_state;
   reg_addr_t        addr;
   logic [7:0]       ctrl_q, vbase_q, vec_next;
   logic [N_SRC-1:0] pending, irq_q, eligible, pend_set, pend_clr;
   logic [1:0]       id_q, win_idx;
   logic             win_valid, dispatch, busy;
   logic             wr_ctrl, wr_vbase, wr_pend, wr_swset;

   assign addr     = reg_addr_t'(cfg_addr);
   assign wr_ctrl  = cfg_w_en && (addr == ADDR_CTRL);
   assign wr_vbase = cfg_w_en && (addr == ADDR_VBASE);
   assign wr_pend  = cfg_w_en && (addr == ADDR_PEND);
   assign wr_swset = cfg_w_en && (addr == ADDR_SWSET_STATUS);

   assign eligible = ctrl_q[CTRL_EN_BIT] ? (pending & ctrl_q[CTRL_MASK_LSB +: N_SRC]) : '0;

   int_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req   (eligible),
      .valid (win_valid),
      .idx   (win_idx)
   );

   // Vector arithmetic is 8-bit on purpose: large bases wrap around.
   assign vec_next = vbase_q + (8'(win_idx) << VEC_SHIFT);
   assign int_en   = {7'b0, ctrl_q[CTRL_EN_BIT]};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         int_req <= 1'b0;
      end else begin
         state   <= next_state;
         int_req <= (next_state == REQ);
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (win_valid) next_state = REQ;
         REQ:     next_state = SERVICE;
         SERVICE: if (ret) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      dispatch = (state == IDLE) && win_valid;
      busy     = (state == REQ) || (state == SERVICE);
   end

   always_comb begin
      pend_set = (irq & ~irq_q) | (wr_swset ? cfg_w_data[N_SRC-1:0] : '0);
      pend_clr = wr_pend ? cfg_w_data[N_SRC-1:0] : '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (dispatch && (win_idx == 2'(i))) pend_clr[i] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         irq_q   <= '0;
         pending <= '0;
         ctrl_q  <= '0;
         vbase_q <= '0;
         id_q    <= '0;
         int_vec <= '0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~pend_clr) | pend_set;
         if (wr_ctrl)  ctrl_q  <= cfg_w_data & CTRL_WMASK;
         if (wr_vbase) vbase_q <= cfg_w_data;
         if (dispatch) begin
            id_q    <= win_idx;
            int_vec <= vec_next;
         end
      end
   end

   always_comb begin
      cfg_r_data = 8'h00;
      case (addr)
         ADDR_CTRL:         cfg_r_data = ctrl_q;
         ADDR_VBASE:        cfg_r_data = vbase_q;
         ADDR_PEND:         cfg_r_data = 8'(pending);
         ADDR_SWSET_STATUS: cfg_r_data = {busy, 5'b0, id_q};
         default:           cfg_r_data = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller with hand-computed expectations.
module tb_int_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic       ret;
   logic       cfg_w_en;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_w_data;
   logic [7:0] cfg_r_data;
   logic       int_req;
   logic [7:0] int_en;
   logic [7:0] int_vec;

   int n_cmp = 0;
   int n_bad = 0;

   int_controller #(.N_SRC(4), .VEC_SHIFT(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .irq        (irq),
      .ret        (ret),
      .cfg_w_en   (cfg_w_en),
      .cfg_addr   (cfg_addr),
      .cfg_w_data (cfg_w_data),
      .cfg_r_data (cfg_r_data),
      .int_req    (int_req),
      .int_en     (int_en),
      .int_vec    (int_vec)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      cfg_addr   = a;
      cfg_w_data = d;
      cfg_w_en   = 1'b1;
      tick();
      cfg_w_en   = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      cfg_addr = a;
      #1;
      check(tag, cfg_r_data, exp);
   endtask

   task automatic pulse_ret();
      ret = 1'b1;
      tick();
      ret = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; irq = '0; ret = 1'b0;
      cfg_w_en = 1'b0; cfg_addr = '0; cfg_w_data = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst_int_req", int_req, 8'h00);
      check("rst_int_vec", int_vec, 8'h00);
      check("rst_int_en",  int_en,  8'h00);
      read_chk("rst_ctrl",   2'd0, 8'h00);
      read_chk("rst_vbase",  2'd1, 8'h00);
      read_chk("rst_pend",   2'd2, 8'h00);
      read_chk("rst_status", 2'd3, 8'h00);

      // single source, two-clock latency, one-cycle request
      cfg_write(2'd0, 8'h11);
      cfg_write(2'd1, 8'h40);
      check("t1_int_en", int_en, 8'h01);
      irq[0] = 1'b1;
      tick();
      check("t1_req_edge", int_req, 8'h00);
      read_chk("t1_pend_set", 2'd2, 8'h01);
      tick();
      check("t1_req", int_req, 8'h01);
      check("t1_vec", int_vec, 8'h40);
      read_chk("t1_status_req", 2'd3, 8'h80);
      read_chk("t1_pend_clr", 2'd2, 8'h00);
      tick();
      check("t1_req_single", int_req, 8'h00);
      read_chk("t1_status_svc", 2'd3, 8'h80);
      irq[0] = 1'b0;
      tick();
      read_chk("t1_status_wait", 2'd3, 8'h80);
      pulse_ret();
      read_chk("t1_status_idle", 2'd3, 8'h00);
      tick();
      check("t1_no_req", int_req, 8'h00);

      // simultaneous edges: source 1 before source 2
      cfg_write(2'd0, 8'hF1);
      irq = 4'b0110;
      tick();
      tick();
      check("t2_req_a", int_req, 8'h01);
      check("t2_vec_a", int_vec, 8'h50);
      tick();
      read_chk("t2_pend_left", 2'd2, 8'h04);
      irq = 4'b0000;
      pulse_ret();
      check("t2_gap", int_req, 8'h00);
      tick();
      check("t2_req_b", int_req, 8'h01);
      check("t2_vec_b", int_vec, 8'h60);
      read_chk("t2_status_b", 2'd3, 8'h82);
      tick();
      pulse_ret();
      read_chk("t2_pend_empty", 2'd2, 8'h00);

      // no nesting, vector wrap, frozen vector on VBASE write
      cfg_write(2'd1, 8'hE0);
      irq[0] = 1'b1;
      tick();
      tick();
      check("t3_vec0", int_vec, 8'hE0);
      tick();
      irq[0] = 1'b0;
      irq[3] = 1'b1;
      tick();
      check("t3_no_nest_a", int_req, 8'h00);
      tick();
      check("t3_no_nest_b", int_req, 8'h00);
      read_chk("t3_pend_held", 2'd2, 8'h08);
      pulse_ret();
      check("t3_gap", int_req, 8'h00);
      tick();
      check("t3_req", int_req, 8'h01);
      check("t3_vec_wrap", int_vec, 8'h10);
      read_chk("t3_status", 2'd3, 8'h83);
      tick();
      cfg_write(2'd1, 8'h40);
      check("t3_vec_frozen", int_vec, 8'h10);
      irq[3] = 1'b0;
      pulse_ret();

      // global enable off, W1C, late enable
      cfg_write(2'd0, 8'h10);
      irq[0] = 1'b1;
      tick();
      tick();
      read_chk("t4_pend_off", 2'd2, 8'h01);
      check("t4_no_req_off", int_req, 8'h00);
      cfg_write(2'd2, 8'h01);
      read_chk("t4_w1c", 2'd2, 8'h00);
      cfg_write(2'd0, 8'h11);
      check("t4_no_req_a", int_req, 8'h00);
      tick();
      check("t4_no_req_b", int_req, 8'h00);
      cfg_write(2'd0, 8'h10);
      irq[0] = 1'b0;
      tick();
      irq[0] = 1'b1;
      tick();
      read_chk("t4_pend_again", 2'd2, 8'h01);
      cfg_write(2'd0, 8'h11);
      check("t4_en_edge", int_req, 8'h00);
      tick();
      check("t4_req", int_req, 8'h01);
      check("t4_vec", int_vec, 8'h40);
      tick();
      irq[0] = 1'b0;
      pulse_ret();

      // SWSET dispatch, W1C racing a dispatch, set beats clear
      cfg_write(2'd0, 8'h41);
      cfg_write(2'd3, 8'h04);
      check("t5_sw_edge", int_req, 8'h00);
      tick();
      check("t5_sw_req", int_req, 8'h01);
      check("t5_sw_vec", int_vec, 8'h60);
      read_chk("t5_sw_status", 2'd3, 8'h82);
      tick();
      pulse_ret();
      cfg_write(2'd3, 8'h04);
      cfg_write(2'd2, 8'h04);
      check("t5_race_req", int_req, 8'h01);
      check("t5_race_vec", int_vec, 8'h60);
      read_chk("t5_race_pend", 2'd2, 8'h00);
      tick();
      pulse_ret();
      cfg_write(2'd0, 8'h40);
      irq[2] = 1'b1;
      cfg_write(2'd2, 8'h04);
      read_chk("t5_set_wins", 2'd2, 8'h04);
      cfg_write(2'd2, 8'h04);
      read_chk("t5_w1c_after", 2'd2, 8'h00);
      irq[2] = 1'b0;
      tick();

      // reset during SERVICE with a pending bit, held-high line re-pends once
      cfg_write(2'd0, 8'hF1);
      irq[0] = 1'b1;
      tick();
      tick();
      tick();
      irq[0] = 1'b0;
      cfg_write(2'd3, 8'h02);
      read_chk("t6_pend_pre", 2'd2, 8'h02);
      read_chk("t6_status_pre", 2'd3, 8'h80);
      reset  = 1'b1;
      irq[3] = 1'b1;
      tick();
      tick();
      check("t6_rst_req", int_req, 8'h00);
      check("t6_rst_vec", int_vec, 8'h00);
      check("t6_rst_en",  int_en,  8'h00);
      read_chk("t6_rst_ctrl",   2'd0, 8'h00);
      read_chk("t6_rst_pend",   2'd2, 8'h00);
      read_chk("t6_rst_status", 2'd3, 8'h00);
      reset = 1'b0;
      tick();
      read_chk("t6_repend", 2'd2, 8'h08);
      cfg_write(2'd2, 8'h08);
      tick();
      tick();
      read_chk("t6_once", 2'd2, 8'h00);
      check("t6_no_req", int_req, 8'h00);
      irq[3] = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/int_controller.md
# int_controller

Interrupt controller for the jacaranda-8 core. It latches up to N_SRC peripheral interrupt lines (UART, timer, GPIO) as pending bits and picks the highest-priority enabled source. It gives the core exactly one single-cycle interrupt request and vector per service, then waits for the core's return strobe before it dispatches again. Software configures it through a small register window decoded by the memory-map logic.

## Interface
Parameters:
- N_SRC, 4: number of interrupt sources (1..4).
- VEC_SHIFT, 4: vector spacing; source i vectors to VBASE + (i << VEC_SHIFT).

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- irq  in  N_SRC  level interrupt lines, synchronous to clock; a rising edge (sampled) raises pending.
- ret  in  1  one-cycle strobe from the core when it executes return-from-interrupt.
- cfg_w_en  in  1  register write strobe.
- cfg_addr  in  2  register select.
- cfg_w_data  in  8  write data.
- cfg_r_data  out  8  read data, combinational from cfg_addr.
- int_req  out  1  interrupt request to the core, registered, one-cycle pulse.
- int_en  out  8  to the core: {7'b0, CTRL[0]}.
- int_vec  out  8  vector to the core, registered, valid while int_req is high.

## Operation
Registers, selected by cfg_addr:
- 0 CTRL (RW): bit0 is the global enable; bits[3+N_SRC:4] are the per-source masks; unused bits read 0.
- 1 VBASE (RW): vector base.
- 2 PEND (R, W1C): pending bits in [N_SRC-1:0].
- 3 (W: SWSET, write 1 sets the corresponding pending bit; R: STATUS = {busy, 4'b0, 1'b0, id[1:0]}). busy=1 in REQ or SERVICE; id is the last dispatched source.

Edge detect:
- irq_q is the previous sample of irq.
- Pending[i] sets when irq[i] & ~irq_q[i], or on a SWSET write.
- Pending[i] clears on a PEND W1C write, or when source i is dispatched.
- Set beats clear in the same cycle.

Eligibility and priority:
- eligible = pending & mask, considered only when CTRL[0]=1.
- Fixed priority: the lowest index wins.

FSM states:
- IDLE: if eligible != 0, go to REQ. Latch id = winner. Load int_vec = VBASE + (winner << VEC_SHIFT), truncated to 8 bits (wraps). Clear pending[winner].
- REQ: int_req=1 for this one cycle only. Unconditionally go to SERVICE.
- SERVICE: wait for ret=1, then go to IDLE. No nesting: new edges only accumulate in pending.

Other rules:
- ret outside SERVICE is ignored.
- Clearing CTRL[0] during SERVICE does not abort the service; it only blocks the next dispatch.
- Vector and id are frozen from IDLE exit until the next dispatch. A VBASE write during REQ/SERVICE does not alter int_vec.

## Timing
- Reset values: state IDLE, CTRL=0, VBASE=0, pending=0, irq_q=0, id=0, int_req=0, int_vec=0, int_en=0.
- Reset mid-REQ/SERVICE returns to IDLE and drops all pending; irq_q=0, so a line still high re-triggers one cycle after reset is released.
- Latency: irq[i] is sampled high at edge k (low at k-1); pending is set after edge k; state is REQ and int_req=1 in the cycle after edge k+1. That is two clocks to the request.
- A SWSET write at edge k produces the same timing as an irq edge.
- int_req is never high for two consecutive cycles. Minimum spacing between requests is ret + 2 cycles (SERVICE→IDLE→REQ).
- A source re-edging during its own SERVICE is held pending and dispatched after ret.
- A W1C of a winner's bit in the same cycle that IDLE dispatches it has no effect; the dispatch stands.
- cfg writes take effect at the clock edge. Reads reflect the current register values.

## Structure
- Shared package int_pkg holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2;
  - register addresses: CTRL, VBASE, PEND, SWSET_STATUS;
  - the CTRL bit positions.
- One sub-module, int_prio_enc: combinational lowest-index-first encoder, N_SRC→{valid, idx[1:0]}.
- Everything else is flat in int_controller.

## Test plan
- CTRL=8'h11, VBASE=8'h40, pulse irq[0] → int_req high for exactly one cycle, two clocks after the edge, with int_vec=8'h40; STATUS reads 8'h80 (busy, id=0) until ret.
- CTRL=8'hF1, irq[2] and irq[1] rise in the same cycle → vector 8'h50 (source 1) first; after ret, source 2 is dispatched with 8'h60 at ret+2.
- irq[3] edge during SERVICE with VBASE=8'hE0 → no int_req until ret; then vector 8'h10 (wrap of 8'hE0+8'h30).
- CTRL=8'h10 (global off), irq[0] edge → PEND reads 8'h01, no int_req. Write CTRL=8'h11 → int_req next+1 cycle. A W1C of 8'h01 before enabling → no request.
- SWSET write 8'h04 with CTRL=8'h41 → dispatch of source 2. The same cycle as a W1C of the same bit → pending stays 1.
- Assert reset during SERVICE with pending=8'h02 → after reset: all outputs 0, PEND=0, state IDLE; a held-high irq re-pends once.
